mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_responder_if.sv | 13 +
 rtl/mem_array.sv | 17 +
 rtl/mem_responder.sv | 82 ++++++++
 tb/tb_mem_responder.sv | 134 +++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: access-size codes, FSM encodings and the access legality check shared by the memory responder.
package mem_pkg;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  // Illegal size codes, unsigned stores, and halves/words off their natural boundary.
  function automatic logic access_err(input logic st, input logic [2:0] f3, input logic [1:0] a);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (st && f3[2]) ||
           ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: processor memory port; the processor is master, the responder is slave.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  modport master (output req, we, addr, wdata, funct3, input rdata, ready, err);
  modport slave  (input req, we, addr, wdata, funct3, output rdata, ready, err);
endinterface

// File: rtl/mem_array.sv
// mem_array: word RAM with per-byte write enables, synchronous write and asynchronous read.
module mem_array #(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [3:0]            i_be,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);
  logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-stated memory responder with alignment checking, byte-lane steering and load extension.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);
  localparam logic [3:0] WAITS = 4'(WAIT_CYCLES);
  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [2:0]            r_f3;
  logic [31:0]           r_rdata;
  logic                  r_ready;
  logic                  r_err;
  logic                  w_err;
  logic                  w_commit;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic [31:0]           w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_ld;
  assign w_err    = access_err(r_we, r_f3, r_addr[1:0]);
  assign w_commit = (r_state == RESP) && !w_err;
  assign w_be     = !(w_commit && r_we) ? 4'b0000 :
                    (r_f3 == SB) ? 4'b0001 << r_addr[1:0] :
                    (r_f3 == SH) ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata  = (r_f3 == SB) ? {4{r_wdata[7:0]}} :
                    (r_f3 == SH) ? {2{r_wdata[15:0]}} : r_wdata;
  assign w_byte   = w_word[{r_addr[1:0], 3'b000} +: 8];
  assign w_half   = w_word[{r_addr[1], 4'b0000} +: 16];
  assign w_ld     = (r_f3 == LB)  ? {{24{w_byte[7]}}, w_byte} :
                    (r_f3 == LH)  ? {{16{w_half[15]}}, w_half} :
                    (r_f3 == LBU) ? {24'b0, w_byte} :
                    (r_f3 == LHU) ? {16'b0, w_half} : w_word;
  mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk     (clk),
    .i_addr  (r_addr[ADDR_WIDTH+1:2]),
    .i_be    (w_be),
    .i_wdata (w_wdata),
    .o_rdata (w_word)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_f3    <= 3'd0;
      r_rdata <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= r_state == RESP;
      r_err   <= (r_state == RESP) && w_err;
      if (w_commit && !r_we) r_rdata <= w_ld;
      if (r_state == IDLE && bus.req) begin
        r_we    <= bus.we;
        r_addr  <= bus.addr[ADDR_WIDTH+1:0];
        r_wdata <= bus.wdata;
        r_f3    <= bus.funct3;
        r_cnt   <= WAITS;
        r_state <= (WAITS == 4'd0) ? RESP : WAIT;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) r_state <= RESP;
      end else if (r_state == RESP) begin
        r_state <= IDLE;
      end
    end
  assign bus.rdata = r_rdata;
  assign bus.ready = r_ready;
  assign bus.err   = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (0, 1 and 3 wait states) driven in lockstep against a byte-level memory model.
module tb_mem_responder;
  import mem_pkg::*;
  localparam int WC[3] = '{0, 1, 3};
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rd [3];
  logic        rdy [3];
  logic        er [3];
  logic [31:0] mem_m [1024];
  logic [31:0] exp_rd = 32'd0;
  int          n_cmp = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  mem_responder_if bus [3] ();
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      assign bus[g].req    = req;
      assign bus[g].we     = we;
      assign bus[g].addr   = addr;
      assign bus[g].wdata  = wdata;
      assign bus[g].funct3 = funct3;
      assign rd[g]  = bus[g].rdata;
      assign rdy[g] = bus[g].ready;
      assign er[g]  = bus[g].err;
      mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES((g == 2) ? 3 : g)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus[g])
      );
    end
  endgenerate
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  function automatic logic model_err(input logic w, input logic [2:0] f, input logic [31:0] a);
    int sz = 1 << f[1:0];
    return !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (w && f > 3'd3) || (a % sz != 0);
  endfunction
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                      input bit extra, input bit rst_mid);
    int          lat [3] = '{0, 0, 0};
    int          cnt [3] = '{0, 0, 0};
    logic [31:0] got_rd [3] = '{0, 0, 0};
    logic        got_err [3] = '{0, 0, 0};
    logic        stray [3] = '{0, 0, 0};
    int          idx = int'(a[11:2]);
    int          sz = 1 << f[1:0];
    logic        e = model_err(w, f, a);
    logic [31:0] v, mask;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; funct3 = f;
    @(posedge clk); #1;
    req = extra; we = 1'b1; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
    if (rst_mid) reset = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin req = 1'b0; reset = 1'b0; end
      for (int k = 0; k < 3; k++)
        if (rdy[k]) begin
          cnt[k]++; lat[k] = c; got_rd[k] = rd[k]; got_err[k] = er[k];
        end else stray[k] |= er[k];
    end
    if (rst_mid) exp_rd = 32'd0;
    else if (!e) begin
      if (w) for (int b = 0; b < sz; b++) mem_m[idx][8*(int'(a[1:0])+b) +: 8] = d[8*b +: 8];
      else begin
        mask = (sz == 4) ? 32'hFFFFFFFF : (32'd1 << (8*sz)) - 32'd1;
        v = (mem_m[idx] >> (8*int'(a[1:0]))) & mask;
        if (f < 3'd4 && v[8*sz-1]) v |= ~mask;
        exp_rd = v;
      end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("w%0d_ready_count", WC[k]), cnt[k], rst_mid ? 0 : 1);
      check($sformatf("w%0d_err_without_ready", WC[k]), stray[k], 0);
      check($sformatf("w%0d_rdata_held", WC[k]), rd[k], exp_rd);
      if (!rst_mid) begin
        check($sformatf("w%0d_latency", WC[k]), lat[k], WC[k] + 1);
        check($sformatf("w%0d_err", WC[k]), got_err[k], e);
        check($sformatf("w%0d_rdata_at_ready", WC[k]), got_rd[k], exp_rd);
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem_m[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("reset_rdata", rd[k], 32'd0);
      check("reset_ready", rdy[k], 0);
      check("reset_err", er[k], 0);
    end
    for (int i = 0; i < 16; i++) xact(1'b1, 32'h100 + 4*i, $urandom, SW, 0, 0);
    xact(1'b1, 32'h40, 32'hDEADBEEF, SW, 0, 0);
    xact(1'b0, 32'h40, 32'd0, LW, 0, 0);
    check("lw_0x40_const", rd[1], 32'hDEADBEEF);
    xact(1'b1, 32'h80, 32'h8001F2A3, SW, 0, 0);
    xact(1'b0, 32'h80, 32'd0, LB, 0, 0);
    check("lb_0x80_const", rd[0], 32'hFFFFFFA3);
    xact(1'b0, 32'h81, 32'd0, LBU, 0, 0);
    check("lbu_0x81_const", rd[1], 32'h000000F2);
    xact(1'b0, 32'h82, 32'd0, LH, 0, 0);
    check("lh_0x82_const", rd[2], 32'hFFFF8001);
    xact(1'b0, 32'h82, 32'd0, LHU, 0, 0);
    check("lhu_0x82_const", rd[0], 32'h00008001);
    xact(1'b1, 32'h41, 32'h00001234, SH, 0, 0);
    check("sh_misaligned_holds_rdata", rd[2], 32'h00008001);
    xact(1'b0, 32'h40, 32'd0, LW, 1, 0);
    check("lw_after_bad_sh_const", rd[2], 32'hDEADBEEF);
    xact(1'b1, 32'h1000, 32'hCAFEF00D, SW, 0, 0);
    xact(1'b0, 32'h0, 32'd0, LW, 0, 0);
    check("wrap_const", rd[1], 32'hCAFEF00D);
    xact(1'b1, 32'h10, 32'h11112222, SW, 0, 0);
    xact(1'b1, 32'h10, 32'h00000055, SW, 0, 1);
    xact(1'b0, 32'h10, 32'd0, LW, 0, 0);
    check("reset_mid_store_const", rd[2], 32'h11112222);
    for (int i = 0; i < 150; i++)
      xact(1'($urandom), ($urandom & 32'hFFFFF000) | (32'h100 + $urandom_range(0, 63)), $urandom,
           3'($urandom), ($urandom_range(0, 3) == 0), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
